// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter that keeps fixed bursts and locked sequences intact.
// Latency: hgrant/hmaster/hmastlock change on the edge after an arbitration cycle; hmaster_data lags one accepted cycle.
// Backpressure: hready low freezes all tracking; hbusreq is only sampled at arbitration points.
// Optional feature macro AHB_ARB_INCR_LIMIT_EN: forces a handover after INCR_LIMIT beats of an INCR burst.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int INCR_LIMIT     = 16
) (
  input  logic                           hclk,
  input  logic                           hresetn,
  input  logic [NUM_MASTERS-1:0]         hbusreq,
  input  logic [NUM_MASTERS-1:0]         hlock,
  input  logic [1:0]                     htrans,
  input  logic [2:0]                     hburst,
  input  logic                           hready,
  input  logic                           hresp,
  output logic [NUM_MASTERS-1:0]         hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster_data,
  output logic                           hmastlock
);

  localparam int MW = $clog2(NUM_MASTERS);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [2:0] HB_WRAP4  = 3'b010;
  localparam logic [2:0] HB_INCR4  = 3'b011;
  localparam logic [2:0] HB_WRAP8  = 3'b100;
  localparam logic [2:0] HB_INCR8  = 3'b101;

  // Catch unsupported configurations at elaboration time.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || DEFAULT_MASTER < 0 ||
      DEFAULT_MASTER >= NUM_MASTERS || INCR_LIMIT < 1) begin : g_param_check
    $error("ahb_bus_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_INCR   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_beat_cnt;
  logic [3:0]      w_beat_nxt;
  logic            r_err_pend;
  logic            w_err_nxt;
  logic [MW-1:0]   r_owner;
  logic [MW-1:0]   r_ptr;
  logic [MW-1:0]   r_data_owner;
  logic            r_mastlock;

  logic [NUM_MASTERS-1:0] w_grant;
  logic            w_own_lock;
  logic            w_accept;
  logic            w_acc_nonseq;
  logic            w_err_first;
  logic            w_lock_hold;
  logic            w_limit;
  logic            w_arb_ok;
  logic [3:0]      w_burst_len;
  logic            w_found;
  logic [MW-1:0]   w_winner;
  logic [MW-1:0]   w_next_owner;
  logic            w_owner_change;

  assign w_own_lock   = hlock[r_owner];
  assign w_accept     = hready & htrans[1];
  assign w_acc_nonseq = w_accept & ~htrans[0];
  assign w_err_first  = hresp & ~hready;

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
  always_comb begin
    w_burst_len = 4'd0;
    case (hburst)
      HB_WRAP4, HB_INCR4: w_burst_len = 4'd3;
      HB_WRAP8, HB_INCR8: w_burst_len = 4'd7;
      HB_SINGLE, HB_INCR: w_burst_len = 4'd0;
      default:            w_burst_len = 4'd15;
    endcase
  end

`ifdef AHB_ARB_INCR_LIMIT_EN
  localparam int LW = $clog2(INCR_LIMIT + 1);
  logic [LW-1:0] r_incr_cnt;

  // Count accepted beats of an INCR burst; a NONSEQ restarts the count at one.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_incr_cnt <= '0;
    end else if (w_acc_nonseq) begin
      r_incr_cnt <= LW'(1);
    end else if (w_accept && r_state == ST_INCR && r_incr_cnt < LW'(INCR_LIMIT)) begin
      r_incr_cnt <= r_incr_cnt + LW'(1);
    end
  end

  assign w_limit = (r_state == ST_INCR) && (r_incr_cnt >= LW'(INCR_LIMIT)) &&
                   (|(hbusreq & ~w_grant));
`else
  assign w_limit = 1'b0;
`endif

  // A locked owner keeps the bus until it idles with hlock released.
  assign w_lock_hold = ((r_state == ST_LOCKED) && !((htrans == TR_IDLE) && !w_own_lock)) ||
                       (w_acc_nonseq && w_own_lock);

  assign w_arb_ok = hready && !w_lock_hold &&
                    (r_err_pend ||
                     ((r_state == ST_IDLE)   && (htrans == TR_IDLE)) ||
                     ((r_state == ST_BURST)  && (r_beat_cnt == 4'd0)) ||
                     ((r_state == ST_INCR)   && ((htrans == TR_IDLE) || (htrans == TR_NONSEQ))) ||
                     (w_acc_nonseq && (hburst == HB_SINGLE)) ||
                     ((r_state == ST_LOCKED) && (htrans == TR_IDLE) && !w_own_lock) ||
                     w_limit);

  // Round-robin scan from pointer+1; the lowest offset with a request wins.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(r_ptr) + k) % NUM_MASTERS;
      if (hbusreq[MW'(idx)]) begin
        w_found  = 1'b1;
        w_winner = MW'(idx);
      end
    end
  end

  assign w_next_owner   = w_found ? w_winner : MW'(DEFAULT_MASTER);
  assign w_owner_change = w_arb_ok && (w_next_owner != r_owner);

  // Burst/lock tracking next-state; a handover always restarts from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_err_nxt   = r_err_pend;
    if (w_err_first) begin
      w_beat_nxt  = 4'd0;
      w_err_nxt   = 1'b1;
      w_state_nxt = ((r_state == ST_LOCKED) && w_own_lock) ? ST_LOCKED : ST_IDLE;
    end else if (hready) begin
      w_err_nxt = 1'b0;
      case (htrans)
        TR_NONSEQ: begin
          w_beat_nxt = w_burst_len;
          if ((r_state == ST_LOCKED) || w_own_lock) begin
            w_state_nxt = ST_LOCKED;
          end else if (hburst == HB_SINGLE) begin
            w_state_nxt = ST_IDLE;
          end else if (hburst == HB_INCR) begin
            w_state_nxt = ST_INCR;
          end else begin
            w_state_nxt = ST_BURST;
          end
        end
        TR_SEQ: begin
          if (r_beat_cnt != 4'd0) begin
            w_beat_nxt = r_beat_cnt - 4'd1;
          end
        end
        TR_IDLE: begin
          if (r_state == ST_LOCKED) begin
            if (!w_own_lock) begin
              w_state_nxt = ST_IDLE;
            end
          end else if ((r_state == ST_INCR) ||
                       ((r_state == ST_BURST) && (r_beat_cnt == 4'd0))) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
        end
      endcase
      if (w_owner_change) begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = 4'd0;
      end
    end
  end

  // State register for the tracking FSM.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= 4'd0;
      r_err_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_err_pend <= w_err_nxt;
    end
  end

  // Owner and round-robin pointer move only at arbitration points; parking leaves the pointer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_owner <= MW'(DEFAULT_MASTER);
      r_ptr   <= MW'(DEFAULT_MASTER);
    end else if (w_arb_ok) begin
      r_owner <= w_next_owner;
      if (w_found) begin
        r_ptr <= w_winner;
      end
    end
  end

  // Data-phase owner and lock flag advance with each ready cycle.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_data_owner <= MW'(DEFAULT_MASTER);
      r_mastlock   <= 1'b0;
    end else if (hready) begin
      r_data_owner <= r_owner;
      r_mastlock   <= (w_state_nxt == ST_LOCKED);
    end
  end

  // One-hot grant decoded from the owner index, so it can never be empty.
  always_comb begin
    w_grant          = '0;
    w_grant[r_owner] = 1'b1;
  end

  assign hgrant       = w_grant;
  assign hmaster      = r_owner;
  assign hmaster_data = r_data_owner;
  assign hmastlock    = r_mastlock;

endmodule
